bus_request_arbiter: RTL and testbench
======================================

// Module: bus_request_arbiter
// PURPOSE
//   Parametrised successor to the single-bus request unit: arbitrates CPU instruction
//   fetch and data load/store onto one memory bus (read_i/write_i/adr_i/cpu_dat_i/sel_i,
//   cpu_dat_o/busy_o). Adds byte/half/word access with lane select, load sign/zero
//   extension, misalignment detection, starvation-bounded priority and a pipeline stall.
// PARAMETERS
//   ADDR_W       32  byte-address width of both request ports and adr_i
//   DATA_W       32  bus data width; 32 or 64 only (64 enables d_size=3, doubleword)
//   I_STARVE_MAX 4   max consecutive data grants while fetch is pending; 0 = strict data priority
// PORTS
//   clk         in   1         clock, all logic on rising edge
//   rst         in   1         synchronous, active-high reset
//   i_req       in   1         fetch request, held high until i_done
//   i_addr      in   ADDR_W    fetch byte address (word aligned; low bits ignored)
//   i_rdata     out  DATA_W    fetched instruction, valid with i_done
//   i_done      out  1         1-cycle pulse: fetch complete
//   d_read      in   1         load request, held until d_done
//   d_write     in   1         store request, held until d_done (d_read wins if both)
//   d_addr      in   ADDR_W    load/store byte address
//   d_wdata     in   DATA_W    store data, right-justified
//   d_size      in   2         0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
//   d_unsigned  in   1         1 = zero-extend load, 0 = sign-extend
//   d_rdata     out  DATA_W    extended load data, valid with d_done
//   d_done      out  1         1-cycle pulse: load/store complete (or rejected)
//   d_err       out  1         1-cycle pulse with d_done: misaligned, no bus access made
//   stall       out  1         high whenever any request is asserted and not yet done
//   read_i      out  1         bus read strobe
//   write_i     out  1         bus write strobe
//   adr_i       out  ADDR_W    bus address, low log2(DATA_W/8) bits forced 0
//   cpu_dat_i   out  DATA_W    bus write data, lane-replicated
//   sel_i       out  DATA_W/8  byte-lane enables
//   cpu_dat_o   in   DATA_W    bus read data, valid when busy_o falls in WAIT
//   busy_o      in   1         bus busy; bus contract: high the cycle after a strobe
// BEHAVIOUR
//   Reset: state IDLE; read_i, write_i, adr_i, cpu_dat_i, sel_i, i_rdata, d_rdata, i_done,
//     d_done, d_err, starve counter all 0. Reset mid-transaction abandons it; no done pulse.
//   All bus outputs and done/rdata outputs registered. stall is combinational.
//   FSM IDLE -> ISSUE -> WAIT -> IDLE:
//     IDLE: when busy_o=0 pick a winner; none -> stay. Misaligned data (addr mod size bytes
//       != 0) -> pulse d_done+d_err next cycle, no strobe, stay IDLE (then re-arbitrate).
//     ISSUE (1 cycle): read_i or write_i =1, adr_i/sel_i/cpu_dat_i driven for winner.
//     WAIT: strobes 0, adr_i/sel_i/cpu_dat_i held. First WAIT cycle ignores busy_o. Later,
//       busy_o=0 -> capture cpu_dat_o, pulse i_done or d_done next cycle, go IDLE.
//     Min latency request-to-done: 4 cycles. Next grant is evaluated in the done cycle.
//   Arbitration: data beats fetch, except when the starve counter = I_STARVE_MAX (>0)
//     and i_req=1 -> fetch wins. Counter +1 per data grant with i_req high, cleared on
//     any fetch grant or when i_req low; saturates at I_STARVE_MAX.
//   Lanes: off = addr mod (DATA_W/8); sel_i = ((1<<2^size)-1) << off; fetch sel_i all ones.
//     cpu_dat_i = low 2^size bytes of d_wdata replicated across the bus width.
//     Load: d_rdata = (cpu_dat_o >> 8*off) truncated to 2^size bytes, then extended.
//   Requester dropping its request during ISSUE/WAIT: bus access completes, done pulse
//     still issued. Requests changing inputs after grant are ignored until done.
// TESTING
//   1 Reset held 2 cycles mid-WAIT -> all outputs 0, state IDLE, no done pulse afterwards.
//   2 i_req, i_addr=0x104, busy_o high cycle 2-3, cpu_dat_o=0x00A00093 -> read_i 1 cycle,
//     adr_i=0x104, sel_i=4'hF, i_done pulse, i_rdata=0x00A00093, stall low after.
//   3 Load byte signed d_addr=0x203, cpu_dat_o=0x80112233 -> sel_i=4'b1000,
//     adr_i=0x200, d_rdata=0xFFFFFF80; same with d_unsigned=1 -> 0x00000080.
//   4 Store half d_addr=0x22, d_wdata=0x1234BEEF -> write_i, sel_i=4'b1100,
//     cpu_dat_i=0xBEEFBEEF, d_done pulse, no d_err.
//   5 Misaligned word load d_addr=0x301 -> d_done+d_err, read_i/write_i never asserted.
//   6 i_req and d_read held continuously, I_STARVE_MAX=2 -> grant order D,D,I,D,D,I;
//     with I_STARVE_MAX=0 fetch granted only after data requests drop.

Source files
------------

// File: rtl/bus_request_arbiter.sv
// -----------------------------------------------------------------------------
// bus_request_arbiter
//   Shares one memory bus between a CPU instruction-fetch port and a data
//   load/store port. Supports byte/half/word (and dword when DATA_W=64)
//   accesses with byte-lane selects, sign/zero extension of loads,
//   misalignment rejection and a bounded-starvation priority for fetch.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_done        fetch request / completion
//   d_read/d_write/d_addr/d_wdata/d_size/d_unsigned
//                  -> d_rdata/d_done/d_err load/store request / completion
//   stall                         some request is pending and not done
//   read_i/write_i/adr_i/cpu_dat_i/sel_i   bus request outputs (registered)
//   cpu_dat_o/busy_o              bus response inputs
// -----------------------------------------------------------------------------
module bus_request_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int I_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_done,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [1:0]          d_size,
  input  logic                d_unsigned,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_done,
  output logic                d_err,
  output logic                stall,
  output logic                read_i,
  output logic                write_i,
  output logic [ADDR_W-1:0]   adr_i,
  output logic [DATA_W-1:0]   cpu_dat_i,
  output logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   cpu_dat_o,
  input  logic                busy_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (I_STARVE_MAX > 0) ? $clog2(I_STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(I_STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t             r_state, w_state_next;
  logic               r_wait_first;
  logic [CNT_W-1:0]   r_starve;
  logic               r_is_fetch;
  logic               r_is_load;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [OFF_W-1:0]   r_off;

  logic               w_d_req;
  logic               w_fetch_wins;
  logic               w_grant_i, w_grant_d, w_reject, w_complete;
  logic [OFF_W-1:0]   w_off;
  logic [4:0]         w_off5;
  logic [3:0]         w_bmask;
  logic [4:0]         w_bytes;
  logic [4:0]         w_rbytes;
  logic               w_misaligned;
  logic [DATA_W/8-1:0] w_sel;
  logic [DATA_W-1:0]  w_wdata_rep;
  logic [DATA_W-1:0]  w_keep;
  logic [DATA_W-1:0]  w_shifted;
  logic               w_sign;
  logic [DATA_W-1:0]  w_load_ext;
  logic [ADDR_W-1:0]  w_i_adr, w_d_adr;
  logic               w_unused;

  assign w_d_req  = d_read | d_write;
  assign w_off    = d_addr[OFF_W-1:0];
  assign w_off5   = 5'(w_off);
  assign w_bmask  = (4'd1 << d_size) - 4'd1;
  assign w_bytes  = 5'd1 << d_size;
  assign w_rbytes = 5'd1 << r_size;
  // A dword request on a 32-bit bus cannot be served, so it is rejected like
  // a misaligned one.
  assign w_misaligned = ((DATA_W == 32) && (d_size == 2'd3)) ||
                        ((w_off & w_bmask[OFF_W-1:0]) != '0);

  assign w_i_adr  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_d_adr  = {d_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused = ^i_addr[OFF_W-1:0];

  // A requester whose done pulse is showing this cycle is no longer waiting.
  assign stall = (i_req & ~i_done) | (w_d_req & ~d_done);

  // Fetch only overrides pending data once data has won I_STARVE_MAX times
  // in a row while fetch was waiting.
  assign w_fetch_wins = i_req &
                        (~w_d_req | ((I_STARVE_MAX > 0) && (r_starve == STARVE_LIM)));

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [OFF_W-1:0] LANE  = OFF_W'(gi);
      localparam logic [4:0]       LANE5 = 5'(gi);
      logic [OFF_W-1:0] w_src;
      // Store data is replicated: lane gi carries byte (gi mod size) of d_wdata.
      assign w_src = LANE & w_bmask[OFF_W-1:0];
      assign w_wdata_rep[8*gi +: 8] = d_wdata[{w_src, 3'b000} +: 8];
      assign w_sel[gi]  = (LANE5 >= w_off5) && (LANE5 < (w_off5 + w_bytes));
      assign w_keep[8*gi +: 8] = (LANE5 < w_rbytes) ? 8'hFF : 8'h00;
    end
  endgenerate

  // Load extraction uses the size/offset latched at grant time.
  assign w_shifted = cpu_dat_o >> {r_off, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    case (r_size)
      2'd0:    w_sign = w_shifted[7];
      2'd1:    w_sign = w_shifted[15];
      2'd2:    w_sign = w_shifted[31];
      default: w_sign = w_shifted[DATA_W-1];
    endcase
    w_sign     = w_sign & ~r_unsigned;
    w_load_ext = (w_shifted & w_keep) | (~w_keep & {DATA_W{w_sign}});
  end

  // Next-state and grant decisions.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_reject     = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!busy_o) begin
          if (w_fetch_wins) begin
            w_grant_i    = 1'b1;
            w_state_next = S_ISSUE;
          end else if (w_d_req) begin
            if (w_misaligned) begin
              w_reject = 1'b1;
            end else begin
              w_grant_d    = 1'b1;
              w_state_next = S_ISSUE;
            end
          end
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        // The bus raises busy_o only the cycle after the strobe, so the first
        // WAIT cycle cannot be trusted.
        if (!r_wait_first && !busy_o) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!i_req || w_grant_i) begin
      r_starve <= '0;
    end else if ((w_grant_d || w_reject) && (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_i       <= 1'b0;
      write_i      <= 1'b0;
      adr_i        <= '0;
      cpu_dat_i    <= '0;
      sel_i        <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
      r_wait_first <= 1'b0;
      r_is_fetch   <= 1'b0;
      r_is_load    <= 1'b0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_off        <= '0;
    end else begin
      read_i       <= 1'b0;
      write_i      <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
      r_wait_first <= (r_state == S_ISSUE);
      if (w_grant_i) begin
        read_i     <= 1'b1;
        adr_i      <= w_i_adr;
        sel_i      <= '1;
        cpu_dat_i  <= '0;
        r_is_fetch <= 1'b1;
      end
      if (w_grant_d) begin
        read_i     <= d_read;
        write_i    <= ~d_read;
        adr_i      <= w_d_adr;
        sel_i      <= w_sel;
        cpu_dat_i  <= w_wdata_rep;
        r_is_fetch <= 1'b0;
        r_is_load  <= d_read;
        r_size     <= d_size;
        r_unsigned <= d_unsigned;
        r_off      <= w_off;
      end
      if (w_reject) begin
        d_done  <= 1'b1;
        d_err   <= 1'b1;
        d_rdata <= '0;
      end
      if (w_complete) begin
        if (r_is_fetch) begin
          i_done  <= 1'b1;
          i_rdata <= cpu_dat_o;
        end else begin
          d_done <= 1'b1;
          if (r_is_load) begin
            d_rdata <= w_load_ext;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_request_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_request_arbiter
//   Directed bench. Instance dut uses I_STARVE_MAX=2, instance dut_z uses
//   I_STARVE_MAX=0; both share request inputs and read data, each has its own
//   bus responder that holds busy_o for busy_len cycles after a strobe.
// -----------------------------------------------------------------------------
module tb_bus_request_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] cpu_dat_o;

  logic [31:0] i_rdata, d_rdata, adr_i, cpu_dat_i;
  logic        i_done, d_done, d_err, stall, read_i, write_i, busy_o;
  logic [3:0]  sel_i;

  logic [31:0] i_rdata_z, d_rdata_z, adr_i_z, cpu_dat_i_z;
  logic        i_done_z, d_done_z, d_err_z, stall_z, read_i_z, write_i_z, busy_o_z;
  logic [3:0]  sel_i_z;

  int n_checks;
  int n_errors;
  int busy_len;
  logic [3:0] busy_cnt, busy_cnt_z;

  bus_request_arbiter #(.ADDR_W(32), .DATA_W(32), .I_STARVE_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
    .d_done(d_done), .d_err(d_err), .stall(stall),
    .read_i(read_i), .write_i(write_i), .adr_i(adr_i), .cpu_dat_i(cpu_dat_i),
    .sel_i(sel_i), .cpu_dat_o(cpu_dat_o), .busy_o(busy_o)
  );

  bus_request_arbiter #(.ADDR_W(32), .DATA_W(32), .I_STARVE_MAX(0)) dut_z (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata_z), .i_done(i_done_z),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_unsigned(d_unsigned), .d_rdata(d_rdata_z),
    .d_done(d_done_z), .d_err(d_err_z), .stall(stall_z),
    .read_i(read_i_z), .write_i(write_i_z), .adr_i(adr_i_z), .cpu_dat_i(cpu_dat_i_z),
    .sel_i(sel_i_z), .cpu_dat_o(cpu_dat_o), .busy_o(busy_o_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus responders: busy the cycle after a strobe, for busy_len cycles.
  always_ff @(posedge clk) begin
    if (rst) busy_cnt <= '0;
    else if (read_i || write_i) busy_cnt <= 4'(busy_len);
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 4'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) busy_cnt_z <= '0;
    else if (read_i_z || write_i_z) busy_cnt_z <= 4'(busy_len);
    else if (busy_cnt_z != 0) busy_cnt_z <= busy_cnt_z - 4'd1;
  end
  assign busy_o   = (busy_cnt != 0);
  assign busy_o_z = (busy_cnt_z != 0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one request (already asserted) to its done pulse on dut, recording
  // strobes and the bus fields seen with them; drops all requests on done.
  task automatic run_txn(input string tag, output int lat, output int n_rd,
                         output int n_wr, output logic [31:0] adr,
                         output logic [3:0] sel, output logic [31:0] wdat,
                         output logic err, output logic stall_at_done);
    bit ok;
    ok = 0; lat = 0; n_rd = 0; n_wr = 0; adr = '0; sel = '0; wdat = '0;
    err = 1'b0; stall_at_done = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (read_i)  n_rd++;
      if (write_i) n_wr++;
      if (read_i || write_i) begin
        adr = adr_i; sel = sel_i; wdat = cpu_dat_i;
      end
      if (i_done || d_done) begin
        lat = c; err = d_err; stall_at_done = stall; ok = 1;
        i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    $display("txn %s: lat=%0d rd=%0d wr=%0d adr=0x%0h sel=0x%0h wdat=0x%0h err=%0d",
             tag, lat, n_rd, n_wr, adr, sel, wdat, err);
  endtask

  initial begin
    int lat, n_rd, n_wr;
    logic [31:0] adr, wdat;
    logic [3:0] sel;
    logic err, st;
    int seq[6];
    int n_seq, n_i_z, n_d_z, n_done, n_strobe;
    bit seen;

    n_checks = 0; n_errors = 0; busy_len = 1;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_size = '0; d_unsigned = 1'b0; cpu_dat_o = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_read_i", 64'(read_i), 0);
    check("rst_write_i", 64'(write_i), 0);
    check("rst_adr_i", 64'(adr_i), 0);
    check("rst_sel_i", 64'(sel_i), 0);
    check("rst_cpu_dat_i", 64'(cpu_dat_i), 0);
    check("rst_dones", 64'({i_done, d_done, d_err}), 0);
    check("rst_rdata", 64'({i_rdata, d_rdata}), 0);
    check("rst_stall", 64'(stall), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch with two busy cycles
    busy_len = 2; cpu_dat_o = 32'h00A00093; i_addr = 32'h104; i_req = 1'b1;
    #1 check("fetch_stall_pending", 64'(stall), 1);
    run_txn("fetch", lat, n_rd, n_wr, adr, sel, wdat, err, st);
    check("fetch_lat", 64'(lat), 5);
    check("fetch_rd_cnt", 64'(n_rd), 1);
    check("fetch_wr_cnt", 64'(n_wr), 0);
    check("fetch_adr", 64'(adr), 64'h104);
    check("fetch_sel", 64'(sel), 64'hF);
    check("fetch_rdata", 64'(i_rdata), 64'h00A00093);
    check("fetch_stall_done", 64'(st), 0);
    @(negedge clk);
    check("fetch_stall_after", 64'(stall), 0);
    check("fetch_done_single", 64'(i_done), 0);

    // Signed byte load at lane 3
    busy_len = 1; cpu_dat_o = 32'h80112233;
    d_addr = 32'h203; d_size = 2'd0; d_unsigned = 1'b0; d_read = 1'b1;
    run_txn("lb", lat, n_rd, n_wr, adr, sel, wdat, err, st);
    check("lb_lat", 64'(lat), 4);
    check("lb_rd_cnt", 64'(n_rd), 1);
    check("lb_adr", 64'(adr), 64'h200);
    check("lb_sel", 64'(sel), 64'h8);
    check("lb_rdata", 64'(d_rdata), 64'hFFFFFF80);
    check("lb_err", 64'(err), 0);
    @(negedge clk);

    // Unsigned byte load
    d_unsigned = 1'b1; d_read = 1'b1;
    run_txn("lbu", lat, n_rd, n_wr, adr, sel, wdat, err, st);
    check("lbu_rdata", 64'(d_rdata), 64'h00000080);
    check("lbu_sel", 64'(sel), 64'h8);
    @(negedge clk);

    // Half store at offset 2
    d_addr = 32'h22; d_size = 2'd1; d_wdata = 32'h1234BEEF; d_unsigned = 1'b0; d_write = 1'b1;
    run_txn("sh", lat, n_rd, n_wr, adr, sel, wdat, err, st);
    check("sh_wr_cnt", 64'(n_wr), 1);
    check("sh_rd_cnt", 64'(n_rd), 0);
    check("sh_adr", 64'(adr), 64'h20);
    check("sh_sel", 64'(sel), 64'hC);
    check("sh_wdat", 64'(wdat), 64'hBEEFBEEF);
    check("sh_err", 64'(err), 0);
    @(negedge clk);

    // Misaligned word load: rejected without a bus access
    d_addr = 32'h301; d_size = 2'd2; d_read = 1'b1;
    run_txn("lw_mis", lat, n_rd, n_wr, adr, sel, wdat, err, st);
    n_strobe = n_rd + n_wr;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (read_i || write_i) n_strobe++;
    end
    check("lw_mis_err", 64'(err), 1);
    check("lw_mis_lat", 64'(lat), 1);
    check("lw_mis_strobes", 64'(n_strobe), 0);

    // Reset for two cycles in the middle of WAIT
    busy_len = 6; cpu_dat_o = 32'hDEADBEEF; i_addr = 32'h50; i_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; i_req = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_strobes", 64'({read_i, write_i}), 0);
    check("midrst_adr_sel", 64'({adr_i, sel_i}), 0);
    check("midrst_outs", 64'({cpu_dat_i, i_done, d_done, d_err}), 0);
    check("midrst_rdata", 64'({i_rdata, d_rdata}), 0);
    rst = 1'b0;
    n_done = 0; n_strobe = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (i_done || d_done) n_done++;
      if (read_i || write_i) n_strobe++;
    end
    check("midrst_no_done", 64'(n_done), 0);
    check("midrst_no_strobe", 64'(n_strobe), 0);
    $display("txn reset_mid_wait: dones=%0d strobes=%0d", n_done, n_strobe);

    // Fetch and load both held continuously
    busy_len = 1; cpu_dat_o = 32'h11223344;
    d_addr = 32'h400; d_size = 2'd2; d_unsigned = 1'b0;
    i_addr = 32'h80; i_req = 1'b1; d_read = 1'b1;
    n_seq = 0; n_i_z = 0; n_d_z = 0;
    for (int c = 0; c < 100 && n_seq < 6; c++) begin
      @(negedge clk);
      if (i_done_z) n_i_z++;
      if (d_done_z) n_d_z++;
      if (d_done) begin seq[n_seq] = 1; n_seq++; end
      else if (i_done) begin seq[n_seq] = 2; n_seq++; end
    end
    d_read = 1'b0;
    check("starve_grants", 64'(n_seq), 6);
    // 1 = data, 2 = fetch; expected D,D,I,D,D,I
    check("starve_g0", 64'(seq[0]), 1);
    check("starve_g1", 64'(seq[1]), 1);
    check("starve_g2", 64'(seq[2]), 2);
    check("starve_g3", 64'(seq[3]), 1);
    check("starve_g4", 64'(seq[4]), 1);
    check("starve_g5", 64'(seq[5]), 2);
    check("strict_no_fetch", 64'(n_i_z), 0);
    check("strict_data_cnt", 64'(n_d_z), 6);
    $display("txn starve: seq=%0d%0d%0d%0d%0d%0d strict_fetch=%0d strict_data=%0d",
             seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], n_i_z, n_d_z);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_done_z) begin seen = 1; break; end
    end
    i_req = 1'b0;
    check("strict_fetch_after_drop", 64'(seen), 1);
    check("strict_fetch_rdata", 64'(i_rdata_z), 64'h11223344);
    $display("txn strict_fetch: done=%0d rdata=0x%0h", seen, i_rdata_z);
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
